// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : stream_pkg
//  Description: Shared definitions for the narrow-word stream packer and its
//               companion unpacker. Holds the default pixel/phrase geometry,
//               the phrase type and the slot placement helper.
//  Contents   : PIXEL_W, PHRASE_WORDS, PHRASE_W, phrase_t, slot_lsb()
//  Revision   : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int PIXEL_W      = 16;
    localparam int PHRASE_WORDS = 8;
    localparam int PHRASE_W     = PIXEL_W * PHRASE_WORDS;

    typedef logic [PHRASE_W-1:0] phrase_t;

    // Bit offset of word slot i inside a phrase. With msb_first set, slot 0
    // occupies the most significant word of the phrase.
    function automatic int slot_lsb(input int i, input bit msb_first,
                                    input int words  = PHRASE_WORDS,
                                    input int word_w = PIXEL_W);
        return msb_first ? (words - 1 - i) * word_w : i * word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phrase_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module     : phrase_hold_reg
//  Description: Single-entry output holding register with valid/ready
//               handshake. Loads a new entry whenever it is empty or its
//               current entry is being taken in the same cycle, so a
//               back-to-back producer sees no bubbles.
//  Ports      : clk, rst_n      clock, asynchronous active-low reset
//               load_en         producer presents an entry this cycle
//               load_data/user  entry payload
//               can_load        register will capture load_en this cycle
//               take            downstream accepts the held entry
//               valid/data/user held entry
//  Revision   : 1.0 - initial release
// ============================================================================
module phrase_hold_reg
    import stream_pkg::*;
#(
    parameter int DATA_W = PHRASE_W,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic [USER_W-1:0] load_user,
    output logic              can_load,
    input  logic              take,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [USER_W-1:0] user
);

    assign can_load = ~valid | take;

    // Payload only changes on a real load, so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            user  <= '0;
        end else if (can_load) begin
            valid <= load_en;
            if (load_en) begin
                data <= load_data;
                user <= load_user;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_word_packer.sv
`default_nettype none
// ============================================================================
//  Module     : stream_word_packer
//  Description: Packs WORDS narrow stream words into one WORD_W*WORDS phrase
//               at full rate. Supports early flush on start-of-frame, an
//               explicit flush request, selectable word order and a per-phrase
//               valid-word count.
//  Ports      : clk_in, rst_in   clock, asynchronous active-low reset
//               valid_in/ready_in/data_in   input word stream
//               newframe_in      word is the first of a frame
//               flush_in         request to emit the pending partial phrase
//               valid_out/ready_out/data_out   phrase stream
//               tuser_out        phrase carries a start of frame
//               count_out        valid words in the phrase (1..WORDS)
//  Revision   : 1.0 - initial release
// ============================================================================
module stream_word_packer
    import stream_pkg::*;
#(
    parameter int               WORD_W         = PIXEL_W,
    parameter int               WORDS          = PHRASE_WORDS,
    parameter bit               MSB_FIRST      = 1'b1,
    parameter bit               FLUSH_ON_FRAME = 1'b1,
    parameter logic [WORD_W-1:0] PAD           = '0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [WORD_W-1:0]            data_in,
    input  logic                         newframe_in,
    input  logic                         flush_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [WORD_W*WORDS-1:0]      data_out,
    output logic                         tuser_out,
    output logic [$clog2(WORDS+1)-1:0]   count_out
);

    localparam int c_kw = $clog2(WORDS);
    localparam int c_cw = $clog2(WORDS + 1);
    localparam int c_pw = WORD_W * WORDS;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(WORDS - 1);

    // Assembly buffer holds at most WORDS-1 words; the final word of a
    // phrase goes straight from data_in into the output register.
    logic [WORD_W-1:0] r_buf [WORDS-1];
    logic [c_kw-1:0]   r_k;
    logic              r_ta;
    // A flush that could not be emitted (output stalled, or the flush cycle
    // was consumed by a frame split) stays pending until it is.
    logic              r_flush_pend;

    logic              w_load_ok;
    logic              w_accept;
    logic              w_flush_req;
    logic              w_k_zero;
    logic              w_k_full;
    logic              w_split_hold;
    logic              w_split;
    logic              w_full;
    logic              w_flush;
    logic              w_emit;
    logic              w_take_word;
    logic [c_pw-1:0]   w_phrase;
    logic [c_cw-1:0]   w_count;
    logic              w_tuser;
    logic [c_cw:0]     w_user_q;

    assign w_flush_req  = flush_in | r_flush_pend;
    assign w_k_zero     = (r_k == '0);
    assign w_k_full     = (r_k == c_k_last);
    // Word would close the current partial phrase as a frame boundary.
    assign w_split_hold = FLUSH_ON_FRAME & newframe_in & ~w_k_zero;

    // Any accept that has to emit a phrase is only allowed when the output
    // register can load; plain appends never depend on the output side.
    assign ready_in = w_load_ok | (~w_k_full & ~w_split_hold & ~w_flush_req);
    assign w_accept = valid_in & ready_in;

    assign w_split     = w_accept & w_split_hold;
    assign w_full      = w_accept & w_k_full & ~w_split;
    assign w_flush     = w_flush_req & (~w_k_zero | w_accept) & ~w_split;
    assign w_emit      = (w_split | w_full | w_flush) & w_load_ok;
    // On a frame split the incoming word starts the next phrase instead.
    assign w_take_word = w_accept & ~w_split;

    assign w_count = c_cw'(r_k) + c_cw'(w_take_word);
    assign w_tuser = w_split ? r_ta : (r_ta | (w_take_word & newframe_in));

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
        localparam int              c_lsb = slot_lsb(gi, MSB_FIRST, WORDS, WORD_W);
        localparam logic [c_kw-1:0] c_idx = c_kw'(gi);
        logic [WORD_W-1:0] w_word;
        if (gi < WORDS - 1) begin : g_buf
            assign w_word = (c_idx < r_k) ? r_buf[gi] :
                            ((c_idx == r_k) && w_take_word) ? data_in : PAD;
        end else begin : g_last
            assign w_word = ((c_idx == r_k) && w_take_word) ? data_in : PAD;
        end
        assign w_phrase[c_lsb +: WORD_W] = w_word;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < WORDS - 1; i++) begin
                r_buf[i] <= '0;
            end
            r_k          <= '0;
            r_ta         <= 1'b0;
            r_flush_pend <= 1'b0;
        end else if (w_split) begin
            r_buf[0]     <= data_in;
            r_k          <= c_kw'(1);
            r_ta         <= 1'b1;
            r_flush_pend <= w_flush_req;
        end else if (w_emit) begin
            r_k          <= '0;
            r_ta         <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < WORDS - 1; i++) begin
                    if (r_k == c_kw'(i)) begin
                        r_buf[i] <= data_in;
                    end
                end
                r_k  <= r_k + c_kw'(1);
                r_ta <= r_ta | newframe_in;
            end
            r_flush_pend <= w_flush_req & ~w_k_zero;
        end
    end

    phrase_hold_reg #(
        .DATA_W (c_pw),
        .USER_W (c_cw + 1)
    ) u_hold (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .load_en   (w_emit),
        .load_data (w_phrase),
        .load_user ({w_count, w_tuser}),
        .can_load  (w_load_ok),
        .take      (ready_out),
        .valid     (valid_out),
        .data      (data_out),
        .user      (w_user_q)
    );

    assign count_out = w_user_q[c_cw:1];
    assign tuser_out = w_user_q[0];

endmodule
`default_nettype wire

// File: tb/tb_stream_word_packer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_stream_word_packer
//  Description: Directed self-checking bench for stream_word_packer. A second
//               instance with LSB-first order and no frame split shares the
//               input stream.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_stream_word_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic         newframe_in;
    logic         flush_in;
    logic         ready_out;
    logic [15:0]  data_in;

    logic         ready_in,  ready_in_b;
    logic         valid_out, valid_out_b;
    logic         tuser_out, tuser_out_b;
    logic [127:0] data_out,  data_out_b;
    logic [3:0]   count_out, count_out_b;

    int total   = 0;
    int bad     = 0;
    int rdy_low = 0;

    always #5 clk = ~clk;

    stream_word_packer dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_in     (data_in),
        .newframe_in (newframe_in),
        .flush_in    (flush_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .tuser_out   (tuser_out),
        .count_out   (count_out)
    );

    stream_word_packer #(
        .MSB_FIRST      (1'b0),
        .FLUSH_ON_FRAME (1'b0)
    ) dut_b (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .valid_in    (valid_in),
        .ready_in    (ready_in_b),
        .data_in     (data_in),
        .newframe_in (newframe_in),
        .flush_in    (flush_in),
        .valid_out   (valid_out_b),
        .ready_out   (ready_out),
        .data_out    (data_out_b),
        .tuser_out   (tuser_out_b),
        .count_out   (count_out_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic nf, input logic fl);
        valid_in    = 1'b1;
        data_in     = w;
        newframe_in = nf;
        flush_in    = fl;
        #1;
        if (!ready_in) rdy_low++;
        tick();
        valid_in    = 1'b0;
        newframe_in = 1'b0;
        flush_in    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        valid_in    = 1'b0;
        newframe_in = 1'b0;
        flush_in    = 1'b0;
        data_in     = '0;
        ready_out   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", valid_out, 0);
        chk("rst_data",  data_out,  0);
        chk("rst_count", count_out, 0);
        chk("rst_tuser", tuser_out, 0);
        chk("rst_ready", ready_in,  1);

        // 1: back-to-back full phrase
        rdy_low = 0;
        for (int w = 1; w <= 7; w++) push(16'(w), 1'b0, 1'b0);
        chk("t1_not_yet", valid_out, 0);
        push(16'h0008, 1'b0, 1'b0);
        chk("t1_valid", valid_out, 1);
        chk("t1_data",  data_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("t1_count", count_out, 8);
        chk("t1_tuser", tuser_out, 0);
        chk("t1_ready_never_low", rdy_low, 0);
        tick();
        chk("t1_drain", valid_out, 0);

        // 2: downstream stall with 16 words
        ready_out = 1'b0;
        rdy_low   = 0;
        for (int w = 1; w <= 15; w++) push(16'(w), 1'b0, 1'b0);
        chk("t2_held_a", data_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("t2_accept15", rdy_low, 0);
        valid_in = 1'b1;
        data_in  = 16'h0010;
        #1;
        chk("t2_ready_low", ready_in, 0);
        tick();
        chk("t2_held_b", data_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("t2_held_valid", valid_out, 1);
        chk("t2_still_low", ready_in, 0);
        ready_out = 1'b1;
        #1;
        chk("t2_ready_up", ready_in, 1);
        chk("t2_first_out", data_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        tick();
        valid_in = 1'b0;
        chk("t2_second", data_out, 128'h0009_000a_000b_000c_000d_000e_000f_0010);
        chk("t2_second_cnt", count_out, 8);
        chk("t2_second_vld", valid_out, 1);
        tick();
        chk("t2_drain", valid_out, 0);

        // 3: start-of-frame early flush
        push(16'h00a1, 1'b0, 1'b0);
        push(16'h00b2, 1'b0, 1'b0);
        push(16'h00c3, 1'b0, 1'b0);
        chk("t3_partial_quiet", valid_out, 0);
        push(16'h00d4, 1'b1, 1'b0);
        chk("t3_split_vld",  valid_out, 1);
        chk("t3_split_data", data_out, 128'h00a1_00b2_00c3_0000_0000_0000_0000_0000);
        chk("t3_split_cnt",  count_out, 3);
        chk("t3_split_tu",   tuser_out, 0);
        for (int w = 1; w <= 7; w++) push(16'h0e00 + 16'(w), 1'b0, 1'b0);
        chk("t3_next_data", data_out, 128'h00d4_0e01_0e02_0e03_0e04_0e05_0e06_0e07);
        chk("t3_next_tu",   tuser_out, 1);
        chk("t3_next_cnt",  count_out, 8);
        tick();

        // 4: explicit flush
        for (int w = 1; w <= 5; w++) push(16'h4000 + 16'(w), 1'b0, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("t4_flush_vld",  valid_out, 1);
        chk("t4_flush_data", data_out, 128'h4001_4002_4003_4004_4005_0000_0000_0000);
        chk("t4_flush_cnt",  count_out, 5);
        chk("t4_flush_tu",   tuser_out, 0);
        tick();
        chk("t4_drain", valid_out, 0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("t4_flush_empty", valid_out, 0);
        for (int w = 1; w <= 7; w++) push(16'h4100 + 16'(w), 1'b0, 1'b0);
        push(16'h4108, 1'b0, 1'b1);
        chk("t4_flush7_cnt",  count_out, 8);
        chk("t4_flush7_data", data_out, 128'h4101_4102_4103_4104_4105_4106_4107_4108);
        tick();

        // 5: LSB-first order, no frame split on the second instance
        do_reset();
        for (int w = 1; w <= 8; w++) push(16'(w), 1'b0, 1'b0);
        chk("t5_lsb_data", data_out_b, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t5_lsb_cnt",  count_out_b, 8);
        chk("t5_lsb_tu",   tuser_out_b, 0);
        for (int w = 1; w <= 8; w++) begin
            push(16'h0010 + 16'(w), (w == 4), 1'b0);
            if (w == 4) begin
                chk("t5_msb_split_cnt",  count_out, 3);
                chk("t5_msb_split_data", data_out, 128'h0011_0012_0013_0000_0000_0000_0000_0000);
                chk("t5_lsb_no_split",   valid_out_b, 0);
            end
        end
        chk("t5_nosplit_data", data_out_b, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
        chk("t5_nosplit_tu",   tuser_out_b, 1);
        chk("t5_nosplit_cnt",  count_out_b, 8);

        // 6: asynchronous reset mid-phrase
        do_reset();
        ready_out = 1'b0;
        for (int w = 1; w <= 8; w++) push(16'(w), 1'b0, 1'b0);
        for (int w = 1; w <= 4; w++) push(16'h0f00 + 16'(w), 1'b0, 1'b0);
        chk("t6_pre_vld", valid_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_vld",  valid_out, 0);
        chk("t6_async_data", data_out,  0);
        chk("t6_async_cnt",  count_out, 0);
        chk("t6_async_tu",   tuser_out, 0);
        chk("t6_async_vld_b", valid_out_b, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ready_out = 1'b1;
        for (int w = 1; w <= 8; w++) push(16'h6000 + 16'(w), 1'b0, 1'b0);
        chk("t6_clean_data", data_out, 128'h6001_6002_6003_6004_6005_6006_6007_6008);
        chk("t6_clean_cnt",  count_out, 8);
        chk("t6_clean_tu",   tuser_out, 0);
        chk("t6_clean_vld",  valid_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
